// File: rtl/unary_dot_product_if.sv
// Operand/result handshake bundle for unary_dot_product.
// The master drives operands and out_ready; the slave (the datapath) returns the result.
interface unary_dot_product_if #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned NUM_PRODS = 16,
    parameter int unsigned TREE_W    = $clog2(NUM_PRODS + 1),
    parameter int unsigned ACC_W     = 2 * WIDTH + $clog2(NUM_PRODS)
);
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_PRODS-1:0][WIDTH-1:0] w;
    logic [NUM_PRODS-1:0][WIDTH-1:0] x;
    logic [NUM_PRODS-1:0]            chan_en;
    logic [TREE_W-1:0]               stream_sum;
    logic                            out_valid;
    logic                            out_ready;
    logic [ACC_W-1:0]                result;
    logic                            overflow;

    modport master (
        output in_valid, w, x, chan_en, out_ready,
        input  in_ready, stream_sum, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, w, x, chan_en, out_ready,
        output in_ready, stream_sum, out_valid, result, overflow
    );
endinterface

// File: rtl/unary_dot_product.sv
// Unary dot product: per-channel w*x pulse trains, popcount tree, binary accumulator.
// Define UDP_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module unary_dot_product #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned NUM_PRODS = 16,
    parameter int unsigned TREE_W    = $clog2(NUM_PRODS + 1),
    parameter int unsigned ACC_W     = 2 * WIDTH + $clog2(NUM_PRODS)
) (
    input logic                clk,
    input logic                reset,
    unary_dot_product_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                      state, state_nx;
    logic [NUM_PRODS-1:0][WIDTH-1:0] outer_q, inner_q, x0_q;
    logic [NUM_PRODS-1:0][WIDTH-1:0] outer_nx, inner_nx, x0_nx;
    logic [NUM_PRODS-1:0][WIDTH-1:0] outer_step, inner_step;
    logic [NUM_PRODS-1:0]            active;
    logic [TREE_W-1:0]               pop, stream_q, stream_nx;
    logic [ACC_W-1:0]                acc_q, acc_nx;
    logic [ACC_W:0]                  sum_ext;
    logic                            carry;
    logic                            ovf_q, ovf_nx;
    logic                            first_q;
    logic                            in_ready_q, out_valid_q;
    logic                            accept;

    // Nested down-counter step and per-cycle pulse popcount
    always_comb begin
        active     = '0;
        outer_step = outer_q;
        inner_step = inner_q;
        pop        = '0;
        for (int i = 0; i < int'(NUM_PRODS); i++) begin
            active[i] = (outer_q[i] != '0) && (inner_q[i] != '0);
            if (active[i]) begin
                if (inner_q[i] > WIDTH'(1)) begin
                    inner_step[i] = inner_q[i] - WIDTH'(1);
                end else if (outer_q[i] > WIDTH'(1)) begin
                    inner_step[i] = x0_q[i];
                    outer_step[i] = outer_q[i] - WIDTH'(1);
                end else begin
                    inner_step[i] = '0;
                    outer_step[i] = '0;
                end
            end
            pop = pop + TREE_W'(active[i]);
        end
    end

    assign accept  = bus.in_valid && in_ready_q && (state == S_IDLE);
    assign sum_ext = (ACC_W+1)'(acc_q) + (ACC_W+1)'(stream_q);
    assign carry   = sum_ext[ACC_W];

    // Next-state and datapath next values
    always_comb begin
        state_nx  = state;
        outer_nx  = outer_q;
        inner_nx  = inner_q;
        x0_nx     = x0_q;
        acc_nx    = acc_q;
        ovf_nx    = ovf_q;
        stream_nx = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_RUN;
                    acc_nx   = '0;
                    ovf_nx   = 1'b0;
                    for (int i = 0; i < int'(NUM_PRODS); i++) begin
                        outer_nx[i] = bus.chan_en[i] ? bus.w[i] : '0;
                        inner_nx[i] = bus.chan_en[i] ? bus.x[i] : '0;
                        x0_nx[i]    = bus.chan_en[i] ? bus.x[i] : '0;
                    end
                end
            end
            S_RUN: begin
                outer_nx = outer_step;
                inner_nx = inner_step;
                ovf_nx   = ovf_q | carry;
`ifdef UDP_SATURATE_EN
                acc_nx   = (carry || ovf_q) ? '1 : sum_ext[ACC_W-1:0];
`else
                acc_nx   = sum_ext[ACC_W-1:0];
`endif
                // The first RUN cycle always passes so an all-idle load still takes one pulse slot
                if (!first_q && (active == '0)) begin
                    state_nx = S_DONE;
                end else begin
                    stream_nx = pop;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            outer_q     <= '0;
            inner_q     <= '0;
            x0_q        <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            first_q     <= 1'b0;
            stream_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nx;
            outer_q     <= outer_nx;
            inner_q     <= inner_nx;
            x0_q        <= x0_nx;
            acc_q       <= acc_nx;
            ovf_q       <= ovf_nx;
            first_q     <= accept;
            stream_q    <= stream_nx;
            in_ready_q  <= (state_nx == S_IDLE);
            out_valid_q <= (state_nx == S_DONE);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = acc_q;
    assign bus.overflow   = ovf_q;
    assign bus.stream_sum = stream_q;
endmodule
